// File: rtl/round_key_sched.sv
// Round-key scheduler: drives an external key-expansion engine, collects the
// round keys it reports into a local store and serves indexed reads to the cipher core.
module round_key_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_accept,
  output logic         ke_enable,
  output logic [127:0] ke_key,
  input  logic         ke_key_ready,
  input  logic [3:0]   ke_round,
  input  logic [127:0] ke_key_out,
  output logic         ke_key_ack,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err,
  output logic         keys_ready,
  output logic         sched_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_RK = 3'd2,
    STORE   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LAST_RND = 4'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic             start_ph_q, start_ph_d;
  logic [3:0]       exp_q, exp_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             ack_q;
  logic             keys_ready_q, keys_ready_d;
  logic             sched_err_q, sched_err_d;
  logic [127:0]     ke_key_q, ke_key_d;
  logic             hs;
  logic             slot_wr;

  logic [127:0]     slot_q [0:NUM_ROUNDS];

  logic             rd_ok;
  logic [127:0]     rd_word;
  logic             rk_valid_q, rk_err_q;
  logic [127:0]     rk_data_q;

  always_comb begin
    state_d      = state_q;
    start_ph_d   = 1'b0;
    exp_d        = exp_q;
    to_cnt_d     = to_cnt_q;
    keys_ready_d = keys_ready_q;
    sched_err_d  = sched_err_q;
    ke_key_d     = ke_key_q;
    key_accept   = 1'b0;
    ke_enable    = 1'b0;
    ke_key_ack   = 1'b0;
    slot_wr      = 1'b0;
    hs           = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        key_accept = 1'b1;
        if (key_valid) begin
          hs           = 1'b1;
          state_d      = START;
          ke_key_d     = key_in;
          keys_ready_d = 1'b0;
          sched_err_d  = 1'b0;
          exp_d        = 4'd1;
          to_cnt_d     = '0;
        end
      end
      // Two cycles: enable low then high, so the engine always sees a rising edge.
      START: begin
        ke_enable  = start_ph_q;
        start_ph_d = ~start_ph_q;
        if (start_ph_q) begin
          state_d  = WAIT_RK;
          to_cnt_d = '0;
        end
      end
      // The engine drops ready one cycle after our ack, so that cycle is ignored.
      WAIT_RK: begin
        ke_enable = (exp_q == 4'd1);
        if (ke_key_ready && !ack_q) begin
          state_d  = STORE;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d      = ERR;
          sched_err_d  = 1'b1;
          keys_ready_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      STORE: begin
        if (ke_round == exp_q) begin
          ke_key_ack = 1'b1;
          slot_wr    = 1'b1;
          if (exp_q == LAST_RND) begin
            state_d      = DONE;
            keys_ready_d = 1'b1;
          end else begin
            exp_d   = exp_q + 4'd1;
            state_d = WAIT_RK;
          end
        end else begin
          state_d      = ERR;
          sched_err_d  = 1'b1;
          keys_ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_ph_q   <= 1'b0;
      exp_q        <= 4'd0;
      to_cnt_q     <= '0;
      ack_q        <= 1'b0;
      keys_ready_q <= 1'b0;
      sched_err_q  <= 1'b0;
      ke_key_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_ph_q   <= start_ph_d;
      exp_q        <= exp_d;
      to_cnt_q     <= to_cnt_d;
      ack_q        <= ke_key_ack;
      keys_ready_q <= keys_ready_d;
      sched_err_q  <= sched_err_d;
      ke_key_q     <= ke_key_d;
    end
  end

  // Slot 0 holds the cipher key itself; slots 1..NUM_ROUNDS come from the engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
    end else begin
      if (hs) slot_q[0] <= key_in;
      if (slot_wr) begin
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
          if (exp_q == 4'(i)) slot_q[i] <= ke_key_out;
        end
      end
    end
  end

  always_comb begin
    rd_ok   = keys_ready_q && (rk_idx <= LAST_RND);
    rd_word = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rk_idx == 4'(i)) rd_word = slot_q[i];
    end
  end

  // Read response uses the keys_ready value from before any same-cycle handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_data_q  <= '0;
    end else begin
      rk_valid_q <= rk_req;
      rk_err_q   <= rk_req && !rd_ok;
      rk_data_q  <= (rk_req && rd_ok) ? rd_word : '0;
    end
  end

  assign ke_key      = ke_key_q;
  assign keys_ready  = keys_ready_q;
  assign sched_error = sched_err_q;
  assign rk_valid    = rk_valid_q;
  assign rk_err      = rk_err_q;
  assign rk_data     = rk_data_q;

endmodule
